// File: rtl/multicycle_pkg.sv
// Shared definitions for the multicycle CPU control FSM and its datapath:
// state encoding, opcodes, ALU operation codes and mux select values.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_REXEC  = 4'd7,
    S_ALUWB  = 4'd8,
    S_ADDIEX = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  // ALU operation codes
  localparam logic [5:0] ALU_ADD = 6'b000000;
  localparam logic [5:0] ALU_SUB = 6'b000001;

  // ALU A-input select
  localparam logic [1:0] ASRC_PC = 2'd0;
  localparam logic [1:0] ASRC_A  = 2'd1;

  // ALU B-input select
  localparam logic [1:0] BSRC_B       = 2'd0;
  localparam logic [1:0] BSRC_FOUR    = 2'd1;
  localparam logic [1:0] BSRC_IMM     = 2'd2;
  localparam logic [1:0] BSRC_IMM_SH2 = 2'd3;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  // Register write-data select
  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;

  // True for every opcode the control FSM knows how to sequence.
  function automatic logic is_legal_op(input logic [5:0] op);
    logic ok;
    case (op)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J: ok = 1'b1;
      default:                                           ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/multicycle_control_retire_counter.sv
// Retired-instruction counter: increments when enabled, wraps naturally,
// cleared by the asynchronous active-low reset.
module retire_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: +1 when a retirement is signalled, otherwise hold.
  always_comb begin
    if (en_i) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle CPU. Outputs are decoded from the
// registered state (plus Op/Funct/mem_ready where a state needs them), so an
// asynchronous reset clears every control strobe immediately.
module multicycle_control #(
  parameter int         CNT_W   = 32,
  parameter logic [5:0] ALU_ADD = 6'b000000,
  parameter logic [5:0] ALU_SUB = 6'b000001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             mem_ready,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [5:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [1:0]       PCWrite,
  output logic [1:0]       MemtoReg,
  output logic [1:0]       IRWrite,
  output logic [1:0]       PCWriteCond,
  output logic             BranchSel,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IorD,
  output logic             RegDst,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state_dbg
);

  import multicycle_pkg::*;

  state_e state_q;
  state_e state_d;
  logic   rdst_q;
  logic   rdst_d;
  logic   retire_en;

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_R:           state_d = S_REXEC;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI:        state_d = S_ADDIEX;
          OP_J:           state_d = S_JUMP;
          default:        state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        // Op is stable from IR; anything other than lw/sw abandons the instruction.
        if (Op == OP_LW) begin
          state_d = S_MEMRD;
        end else if (Op == OP_SW) begin
          state_d = S_MEMWR;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEMRD: begin
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else begin
          state_d = S_MEMRD;
        end
      end
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_MEMWR;
        end
      end
      S_REXEC:  state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_ADDIEX: state_d = S_ALUWB;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Destination-register flag: captured when entering write-back, rd for R-type.
  always_comb begin
    if (state_d == S_ALUWB) begin
      rdst_d = (state_q == S_REXEC);
    end else begin
      rdst_d = rdst_q;
    end
  end

  // An instruction retires when a completing state hands back to fetch.
  always_comb begin
    if ((state_d == S_FETCH) &&
        (state_q inside {S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_JUMP})) begin
      retire_en = 1'b1;
    end else begin
      retire_en = 1'b0;
    end
  end

  // State and RegDst flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RESET;
      rdst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rdst_q  <= rdst_d;
    end
  end

  // Datapath control decode from the current state.
  always_comb begin
    ALUSrcA     = ASRC_PC;
    ALUSrcB     = BSRC_B;
    ALUOp       = ALU_ADD;
    PCSource    = PCSRC_ALU;
    PCWrite     = 2'b00;
    MemtoReg    = M2R_ALUOUT;
    IRWrite     = 2'b00;
    PCWriteCond = 2'b00;
    BranchSel   = 1'b0;
    RegWrite    = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IorD        = 1'b0;
    RegDst      = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = BSRC_FOUR;
        // IR and PC latch only in the cycle the instruction word arrives.
        if (mem_ready) begin
          IRWrite = 2'b01;
          PCWrite = 2'b01;
        end else begin
          IRWrite = 2'b00;
          PCWrite = 2'b00;
        end
      end
      S_DECODE: begin
        ALUSrcB = BSRC_IMM_SH2;
        illegal = ~is_legal_op(Op);
      end
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = ASRC_A;
        ALUSrcB = BSRC_IMM;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = M2R_MDR;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_REXEC: begin
        ALUSrcA = ASRC_A;
        ALUOp   = Funct;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = rdst_q;
      end
      S_BRANCH: begin
        ALUSrcA     = ASRC_A;
        ALUOp       = ALU_SUB;
        PCWriteCond = 2'b01;
        PCSource    = PCSRC_ALUOUT;
        BranchSel   = Op[0];
      end
      S_JUMP: begin
        PCWrite  = 2'b01;
        PCSource = PCSRC_JUMP;
      end
      default: begin
        ALUOp = ALU_ADD;
      end
    endcase
  end

  retire_counter #(
    .W (CNT_W)
  ) u_retire_counter (
    .clk     (clk),
    .rst_n   (reset),
    .en_i    (retire_en),
    .count_o (retired)
  );

  assign state_dbg = state_q;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle CPU; sits directly upstream of the datapath and drives every datapath control input.
- Sequences each instruction through fetch, decode, execute, memory and write-back states based on the IR opcode/funct fields fed back from the datapath.
- Moore-style: all outputs decode from the registered state, plus opcode/funct where noted.
- Also provides a memory wait handshake, an illegal-opcode flag and a retired-instruction counter.

Parameters:
- CNT_W, 32, width of retired-instruction counter
- ALU_ADD, 6'b000000, ALUOp code for add (fetch PC+4, address calc)
- ALU_SUB, 6'b000001, ALUOp code for subtract (branch compare)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- Op  in  6  IR[31:26]
- Funct  in  6  IR[5:0]
- mem_ready  in  1  memory access complete this cycle
- ALUSrcA  out  2  0=PC, 1=A
- ALUSrcB  out  2  0=B, 1=const 4, 2=sext imm, 3=sext imm<<2
- ALUOp  out  6  ALU operation code
- PCSource  out  2  0=ALU result, 1=ALUOut, 2=jump target
- PCWrite  out  2  bit0=unconditional PC write; bit1 always 0
- MemtoReg  out  2  0=ALUOut, 1=MDR
- IRWrite  out  2  bit0=latch IR; bit1 always 0
- PCWriteCond  out  2  bit0=conditional branch write; bit1 always 0
- BranchSel  out  1  0=take on Zero (beq), 1=take on !Zero (bne)
- RegWrite  out  1  register file write
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IorD  out  1  0=PC address, 1=ALUOut address
- RegDst  out  1  0=rt, 1=rd
- illegal  out  1  one-cycle pulse on unsupported opcode
- retired  out  CNT_W  instructions completed since reset
- state_dbg  out  4  current state encoding

Behaviour:
- Reset (reset==0, async):
  - state=S_RESET; retired=0.
  - All outputs 0; ALUOp=ALU_ADD.
- Release: S_RESET -> S_FETCH on the first clock.
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, bne=000101, addi=001000, j=000010.
- S_FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=ALU_ADD, PCSource=0.
  - While mem_ready=0: stay; IRWrite and PCWrite stay 0.
  - Cycle with mem_ready=1: IRWrite=2'b01, PCWrite=2'b01; go to S_DECODE.
- S_DECODE:
  - ALUSrcA=0, ALUSrcB=3, ALUOp=ALU_ADD (branch target into ALUOut).
  - Next state by Op: lw/sw->S_MEMADR; R->S_REXEC; beq/bne->S_BRANCH; addi->S_ADDIEX; j->S_JUMP.
  - Any other Op: illegal=1 this cycle, retired unchanged, ->S_FETCH.
- S_MEMADR: ALUSrcA=1, ALUSrcB=2, ALUOp=ALU_ADD; lw->S_MEMRD, sw->S_MEMWR.
- S_MEMRD: MemRead=1, IorD=1; hold until mem_ready=1, then ->S_MEMWB.
- S_MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; ->S_FETCH.
- S_MEMWR: MemWrite=1, IorD=1; hold until mem_ready=1, then ->S_FETCH.
- S_REXEC: ALUSrcA=1, ALUSrcB=0, ALUOp=Funct; ->S_ALUWB.
- S_ALUWB:
  - RegWrite=1, MemtoReg=0.
  - RegDst=1 if it follows S_REXEC, 0 if it follows S_ADDIEX; a 1-bit flag registered on entry selects this.
  - ->S_FETCH.
- S_ADDIEX: ALUSrcA=1, ALUSrcB=2, ALUOp=ALU_ADD; ->S_ALUWB.
- S_BRANCH:
  - ALUSrcA=1, ALUSrcB=0, ALUOp=ALU_SUB, PCWriteCond=2'b01, PCSource=1.
  - BranchSel=Op[0].
  - ->S_FETCH.
- S_JUMP: PCWrite=2'b01, PCSource=2; ->S_FETCH.
- Memory strobes: MemRead and MemWrite are held stable for the whole wait.
- Retired counter:
  - Increments by 1 on every transition into S_FETCH from S_MEMWB, S_MEMWR (on mem_ready), S_ALUWB, S_BRANCH or S_JUMP.
  - Wraps modulo 2^CNT_W.
  - Illegal opcodes do not count.
- Outputs not listed for a state are 0 (ALUOp defaults to ALU_ADD).
- Reset asserted mid-instruction: immediate return to S_RESET values, regardless of mem_ready.
- Latencies (mem_ready tied 1): R/addi 4 cycles, lw 5, sw 4, beq/bne 3, j 3.

Decomposition:
- Shared package multicycle_pkg:
  - State encoding localparams (S_RESET=0 ... S_JUMP).
  - Opcode constants.
  - ALU_ADD/ALU_SUB.
  - ALUSrcB/PCSource/MemtoReg mux select constants; the datapath reuses the same package.
- One sub-module, retire_counter: counter with enable and async active-low clear.
- FSM: next-state and output decode in the top level.

Test Plan:
- Reset held low, clk toggling -> all outputs 0, retired=0, state_dbg=0; one cycle after release state_dbg=S_FETCH, MemRead=1, ALUSrcB=1.
- Op=000000, Funct=100000, mem_ready=1 -> sequence FETCH, DECODE, REXEC (ALUOp=6'b100000), ALUWB (RegWrite=1, RegDst=1), back to FETCH; retired=1.
- Op=100011, mem_ready low 3 cycles in S_MEMRD -> MemRead=1 and IorD=1 held 4 cycles, then S_MEMWB with MemtoReg=1, RegWrite=1; retired increments once.
- Op=000101 -> S_BRANCH with PCWriteCond=2'b01, BranchSel=1, ALUOp=ALU_SUB, PCSource=1; Op=000100 gives BranchSel=0.
- Op=111111 -> illegal pulses exactly one cycle in S_DECODE, next state S_FETCH, retired unchanged.
- reset pulled low during S_MEMWR with mem_ready=0 -> MemWrite drops to 0 asynchronously, before the next clk edge; counter preloaded to all-ones wraps to 0 on next retire.
